// File: rtl/ram_arbiter.sv
// Serialises CPU MEM-stage and loader accesses onto one single-port data RAM.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed CPU priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, LATCH, DONE} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
    logic                  grant_ldr;

    // Winner of the IDLE sample: 1 = loader, 0 = CPU. A lone requester always wins.
    always_comb begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        if (cpu_req && ldr_req) grant_ldr = ~owner_q;
        else                    grant_ldr = ldr_req;
`else
        grant_ldr = ldr_req && !cpu_req;
`endif
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    owner_d = grant_ldr;
                    we_d    = grant_ldr ? ldr_we    : cpu_we;
                    addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
                    wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = we_q ? DONE : LATCH;
            LATCH: begin
                // RAM read data is registered, so it is only valid the cycle after ACCESS.
                if (owner_q) ldr_rdata_d = ram_data;
                else         cpu_rdata_d = ram_data;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    // RAM strobes decode the current state, so a write in ACCESS commits even if reset is high.
    always_comb begin
        ram_address    = (state_q == ACCESS || state_q == LATCH) ? addr_q : '0;
        ram_write_data = (state_q == ACCESS) ? wdata_q : '0;
        ram_wren       = (state_q == ACCESS) && we_q;
        cpu_ack        = (state_q == DONE) && !owner_q;
        ldr_ack        = (state_q == DONE) && owner_q;
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level model of grant order,
// latency and memory contents, with a registered-read RAM behind the arbiter.
module tb_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ldr_req, ldr_we, ldr_ack;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata, ldr_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_write_data;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic          busy, owner;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .ram_address(ram_address), .ram_write_data(ram_write_data), .ram_wren(ram_wren),
        .ram_data(ram_data), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read, zero-initialised.
    bit [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_address] <= ram_write_data;
        ram_data <= mem[ram_address];
    end

    // Reference model: expected memory contents, per-port read data, last served port.
    bit [DW-1:0]   shadow [int];
    logic [DW-1:0] exp_rdata [2];
    bit            last_ldr;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit            got;
        bit            port;
        bit            both;
        int            cyc;
        int            wren_cnt;
        int            idle_cnt;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic [DW-1:0] rdata;
        logic [DW-1:0] other_rdata;
    } obs_t;

    function automatic logic [DW-1:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : '0;
    endfunction

    task automatic issue(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
        else      begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    endtask

    // Advances clock by clock, observing at the negedge, until either ack is seen.
    task automatic wait_any_ack(input int budget, output obs_t o);
        o = '{default: '0};
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            o.cyc++;
            @(negedge clk);
            if (!busy) o.idle_cnt++;
            if (ram_wren) begin
                o.wren_cnt++;
                o.wr_addr = ram_address;
                o.wr_data = ram_write_data;
            end
            if (cpu_ack || ldr_ack) begin
                o.got         = 1'b1;
                o.port        = ldr_ack;
                o.both        = cpu_ack && ldr_ack;
                o.rdata       = ldr_ack ? ldr_rdata : cpu_rdata;
                o.other_rdata = ldr_ack ? cpu_rdata : ldr_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack); else passed++;
        total++; if (ldr_ack !== 1'b0) $display("FAIL reset_ldr_ack: got %b expected 0", ldr_ack); else passed++;
        total++; if (cpu_rdata !== '0) $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); else passed++;
        total++; if (ldr_rdata !== '0) $display("FAIL reset_ldr_rdata: got %h expected 0", ldr_rdata); else passed++;
        total++; if (ram_wren !== 1'b0) $display("FAIL reset_ram_wren: got %b expected 0", ram_wren); else passed++;
        total++; if (ram_address !== '0) $display("FAIL reset_ram_address: got %h expected 0", ram_address); else passed++;
        total++; if (ram_write_data !== '0) $display("FAIL reset_ram_write_data: got %h expected 0", ram_write_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL reset_owner: got %b expected 1", owner); else passed++;
        reset = 1'b0;
        last_ldr     = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic test_ldr_write_cpu_read;
        obs_t o;
        issue(1'b1, 1'b1, 14'h010, 32'hDEADBEEF);
        wait_any_ack(20, o);
        ldr_req = 1'b0;
        total++; if (!o.got) $display("FAIL lw_timeout: no ack within 20 cycles"); else passed++;
        total++; if (o.port !== 1'b1) $display("FAIL lw_port: got %b expected 1", o.port); else passed++;
        total++; if (o.cyc != 2) $display("FAIL lw_latency: got %0d expected 2", o.cyc); else passed++;
        total++; if (o.wren_cnt != 1) $display("FAIL lw_wren_cycles: got %0d expected 1", o.wren_cnt); else passed++;
        total++; if (o.wr_addr !== 14'h010) $display("FAIL lw_ram_addr: got %h expected 010", o.wr_addr); else passed++;
        total++; if (o.wr_data !== 32'hDEADBEEF) $display("FAIL lw_ram_wdata: got %h expected deadbeef", o.wr_data); else passed++;
        total++; if (o.rdata !== exp_rdata[1]) $display("FAIL lw_rdata_hold: got %h expected %h", o.rdata, exp_rdata[1]); else passed++;
        shadow[32'h010] = 32'hDEADBEEF;
        last_ldr = 1'b1;
        @(posedge clk); @(negedge clk);

        issue(1'b0, 1'b0, 14'h010, 32'h0BADF00D);
        wait_any_ack(20, o);
        cpu_req = 1'b0;
        total++; if (!o.got) $display("FAIL cr_timeout: no ack within 20 cycles"); else passed++;
        total++; if (o.port !== 1'b0) $display("FAIL cr_port: got %b expected 0", o.port); else passed++;
        total++; if (o.cyc != 3) $display("FAIL cr_latency: got %0d expected 3", o.cyc); else passed++;
        total++; if (o.wren_cnt != 0) $display("FAIL cr_wren_cycles: got %0d expected 0", o.wren_cnt); else passed++;
        total++; if (o.rdata !== 32'hDEADBEEF) $display("FAIL cr_rdata: got %h expected deadbeef", o.rdata); else passed++;
        total++; if (o.other_rdata !== exp_rdata[1]) $display("FAIL cr_ldr_rdata_hold: got %h expected %h", o.other_rdata, exp_rdata[1]); else passed++;
        exp_rdata[0] = 32'hDEADBEEF;
        last_ldr = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back;
        obs_t o;
        issue(1'b0, 1'b1, 14'h3FFF, 32'h12345678);
        wait_any_ack(20, o);
        total++; if (!o.got) $display("FAIL b2b_wr_timeout: no ack within 20 cycles"); else passed++;
        total++; if (o.cyc != 2) $display("FAIL b2b_wr_latency: got %0d expected 2", o.cyc); else passed++;
        total++; if (o.wr_addr !== 14'h3FFF) $display("FAIL b2b_wr_addr: got %h expected 3fff", o.wr_addr); else passed++;
        total++; if (o.rdata !== exp_rdata[0]) $display("FAIL b2b_wr_rdata_hold: got %h expected %h", o.rdata, exp_rdata[0]); else passed++;
        shadow[32'h3FFF] = 32'h12345678;
        // Keep req high with a new read so the following IDLE starts it immediately.
        issue(1'b0, 1'b0, 14'h3FFF, $urandom);
        wait_any_ack(20, o);
        cpu_req = 1'b0;
        total++; if (!o.got) $display("FAIL b2b_rd_timeout: no ack within 20 cycles"); else passed++;
        total++; if (o.cyc != 4) $display("FAIL b2b_rd_latency: got %0d expected 4", o.cyc); else passed++;
        total++; if (o.idle_cnt != 1) $display("FAIL b2b_idle_cycles: got %0d expected 1", o.idle_cnt); else passed++;
        total++; if (o.rdata !== 32'h12345678) $display("FAIL b2b_rd_data: got %h expected 12345678", o.rdata); else passed++;
        exp_rdata[0] = 32'h12345678;
        last_ldr = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_tie;
        obs_t          o;
        int            left [2];
        bit            p_we [2];
        logic [AW-1:0] p_addr [2];
        logic [DW-1:0] p_data [2];
        bit            exp_port;
        bit            first;
        int            exp_cyc;
        logic [DW-1:0] exp_rd;
        left[0] = 4;
        left[1] = 4;
        for (int p = 0; p < 2; p++) begin
            p_we[p]   = 1'($urandom_range(0, 1));
            p_addr[p] = AW'(14'h100 + $urandom_range(0, 7));
            p_data[p] = $urandom;
            issue(1'(p), p_we[p], p_addr[p], p_data[p]);
        end
        first = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_port = (cpu_req && ldr_req) ? (RR ? !last_ldr : 1'b0) : ldr_req;
            exp_cyc  = (p_we[exp_port] ? 2 : 3) + (first ? 0 : 1);
            exp_rd   = p_we[exp_port] ? exp_rdata[exp_port] : shadow_rd(int'(p_addr[exp_port]));
            wait_any_ack(30, o);
            total++; if (!o.got) $display("FAIL tie_timeout[%0d]: no ack within 30 cycles", k); else passed++;
            total++; if (o.port !== exp_port) $display("FAIL tie_grant[%0d]: got port %b expected %b", k, o.port, exp_port); else passed++;
            total++; if (o.both) $display("FAIL tie_ack_overlap[%0d]: got both acks expected one", k); else passed++;
            total++; if (o.cyc != exp_cyc) $display("FAIL tie_latency[%0d]: got %0d expected %0d", k, o.cyc, exp_cyc); else passed++;
            total++; if (o.rdata !== exp_rd) $display("FAIL tie_rdata[%0d]: got %h expected %h", k, o.rdata, exp_rd); else passed++;
            total++; if (o.other_rdata !== exp_rdata[!exp_port]) $display("FAIL tie_other_rdata[%0d]: got %h expected %h", k, o.other_rdata, exp_rdata[!exp_port]); else passed++;
            if (p_we[exp_port]) shadow[int'(p_addr[exp_port])] = p_data[exp_port];
            else                exp_rdata[exp_port] = exp_rd;
            last_ldr = exp_port;
            left[exp_port]--;
            if (left[exp_port] > 0) begin
                p_we[exp_port]   = 1'($urandom_range(0, 1));
                p_addr[exp_port] = AW'(14'h100 + $urandom_range(0, 7));
                p_data[exp_port] = $urandom;
                issue(exp_port, p_we[exp_port], p_addr[exp_port], p_data[exp_port]);
            end else if (exp_port) begin
                ldr_req = 1'b0;
            end else begin
                cpu_req = 1'b0;
            end
            first = 1'b0;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_latch;
        obs_t o;
        bit   seen_ack;
        issue(1'b1, 1'b0, 14'h010, '0);
        wait_any_ack(20, o);
        ldr_req = 1'b0;
        total++; if (o.rdata !== shadow_rd(32'h010)) $display("FAIL rl_pre_read: got %h expected %h", o.rdata, shadow_rd(32'h010)); else passed++;
        @(posedge clk); @(negedge clk);
        issue(1'b1, 1'b0, 14'h010, '0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        total++; if (!(busy === 1'b1 && ram_address === 14'h010 && ram_wren === 1'b0)) $display("FAIL rl_in_latch: got busy=%b addr=%h wren=%b expected 1/010/0", busy, ram_address, ram_wren); else passed++;
        reset   = 1'b1;
        ldr_req = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL rl_busy: got %b expected 0", busy); else passed++;
        total++; if (ldr_ack !== 1'b0) $display("FAIL rl_ldr_ack: got %b expected 0", ldr_ack); else passed++;
        total++; if (ldr_rdata !== '0) $display("FAIL rl_ldr_rdata: got %h expected 0", ldr_rdata); else passed++;
        total++; if (cpu_rdata !== '0) $display("FAIL rl_cpu_rdata: got %h expected 0", cpu_rdata); else passed++;
        total++; if (owner !== 1'b1) $display("FAIL rl_owner: got %b expected 1", owner); else passed++;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_ldr     = 1'b1;
        seen_ack = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ack || ldr_ack || busy) seen_ack = 1'b1;
        end
        total++; if (seen_ack) $display("FAIL rl_quiet_after_reset: got activity expected none"); else passed++;
    endtask

    task automatic test_reset_write;
        obs_t o;
        bit   seen_ack;
        issue(1'b0, 1'b1, 14'h0AA, 32'h55);
        @(posedge clk); @(negedge clk);
        total++; if (!(ram_wren === 1'b1 && ram_address === 14'h0AA)) $display("FAIL rw_in_access: got wren=%b addr=%h expected 1/0aa", ram_wren, ram_address); else passed++;
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        total++; if (cpu_ack !== 1'b0) $display("FAIL rw_cpu_ack: got %b expected 0", cpu_ack); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rw_busy: got %b expected 0", busy); else passed++;
        shadow[32'h0AA] = 32'h55;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        last_ldr     = 1'b1;
        seen_ack = 1'b0;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ack || ldr_ack) seen_ack = 1'b1;
        end
        total++; if (seen_ack) $display("FAIL rw_no_ack: got ack expected none"); else passed++;
        issue(1'b0, 1'b0, 14'h0AA, '0);
        wait_any_ack(20, o);
        cpu_req = 1'b0;
        total++; if (!o.got) $display("FAIL rw_rd_timeout: no ack within 20 cycles"); else passed++;
        total++; if (o.cyc != 3) $display("FAIL rw_rd_latency: got %0d expected 3", o.cyc); else passed++;
        total++; if (o.rdata !== shadow_rd(32'h0AA)) $display("FAIL rw_rd_data: got %h expected %h", o.rdata, shadow_rd(32'h0AA)); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req   = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        last_ldr  = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        test_reset;
        test_ldr_write_cpu_read;
        test_back_to_back;
        test_tie;
        test_reset_latch;
        test_reset_write;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-port data RAM between two requesters: the CPU MEM stage and the program/debug loader. Each requester has a req/ack handshake, and the arbiter serialises their accesses onto the RAM port one transaction at a time. It sits between the MEM stage, the loader and the RAM instance, and replaces the direct MEM-to-RAM connection. The CPU stage controller holds the MEM stage while `cpu_ack` is pending.

## Interface
Parameters:
- ADDR_WIDTH, 14, RAM word-address width
- DATA_WIDTH, 32, RAM data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU MEM-stage request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  ADDR_WIDTH  CPU access address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  CPU read data; valid when cpu_ack is high on a read
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata  (same directions, widths and meanings as cpu_*) loader port
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_write_data  out  DATA_WIDTH  to RAM write data
- ram_wren  out  1  to RAM write enable
- ram_data  in  DATA_WIDTH  RAM registered read data; valid one cycle after the address is presented
- busy  out  1  high in every state except IDLE
- owner  out  1  current or last granted port; 0 = CPU, 1 = loader

## Operation
- FSM states: IDLE, ACCESS, LATCH, DONE.
- **IDLE:** sample cpu_req and ldr_req.
  - If either is high, pick a winner.
  - Register the winner's we, addr and wdata, plus owner.
  - Go to ACCESS.
  - If neither is high, stay in IDLE.
- **ACCESS:**
  - ram_address = registered addr.
  - ram_write_data = registered wdata.
  - ram_wren = registered we (decoded from state, combinational).
  - Next state: write goes to DONE; read goes to LATCH.
- **LATCH:**
  - ram_address is held.
  - ram_data is registered into the owner's rdata at the end of the cycle.
  - Go to DONE.
- **DONE:**
  - The owner's ack is high for exactly this cycle.
  - The other port's ack stays low.
  - Go to IDLE, unconditionally.
- Arbitration: a lone requester always wins. A tie is resolved by the policy in Configuration.
- The non-owner's rdata holds its previous value.
- A write transaction leaves the owner's rdata unchanged.
- Outside ACCESS and LATCH: ram_wren = 0 and ram_address = 0.
- Requester rules:
  - Drop req at the clock edge where ack is seen high, so req is low in the following IDLE.
  - A req still high in that IDLE is treated as a new transaction.
  - Changing addr, wdata or we while req is high before ack has no effect, because they are latched in IDLE.

## Timing
- Reset values: state = IDLE; cpu_ack = ldr_ack = 0; cpu_rdata = ldr_rdata = 0; ram_wren = 0; ram_address = 0; ram_write_data = 0; busy = 0; owner = 1 (loader marked as last served).
- Read latency: req seen high at IDLE edge N; ACCESS in cycle N+1, LATCH in N+2; ack and rdata valid in N+3.
- Write latency: ACCESS in N+1 (RAM commits at the end of that cycle); ack in N+2.
- Throughput: one IDLE cycle between consecutive transactions. Back-to-back reads take 4 cycles each; writes take 3.
- Reset mid-operation:
  - The next edge forces IDLE and clears acks and busy.
  - No ack is issued for the abandoned transaction.
  - A write whose ACCESS cycle coincides with reset high still commits, because ram_wren is decoded from the current state.
- Loader is granted while the CPU is stalled: the CPU waits; no starvation beyond one transaction under round-robin.

## Configuration
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the port that is not `owner` (the port not last served). After reset, the CPU wins the first tie.
- Not defined: fixed priority; the CPU always wins ties. The loader is served only when cpu_req is low in IDLE.

## Test plan
- Loader write addr 0x010 data 0xDEADBEEF; CPU read 0x010 → ram_wren high one cycle in ACCESS; cpu_ack 3 cycles after the IDLE sample edge; cpu_rdata = 0xDEADBEEF.
- cpu_req and ldr_req both asserted and re-asserted after each ack, with RAM_ARBITER_ROUND_ROBIN_EN defined → grant order CPU, loader, CPU, loader; acks never overlap.
- Same stimulus without RAM_ARBITER_ROUND_ROBIN_EN → CPU served on every tie; loader served only after cpu_req stays low.
- CPU write then immediate CPU read of 0x3FFF (top address), data 0x12345678 → write ack at +2; read returns 0x12345678; exactly one IDLE cycle between the two transactions.
- Reset asserted during LATCH of a loader read → next cycle IDLE, ldr_ack never pulses, busy = 0, ldr_rdata = 0.
- Reset asserted during ACCESS of a CPU write 0x0AA ← 0x55 → no cpu_ack; a subsequent read of 0x0AA returns 0x55.
